// File: rtl/adc_iface_pkg.sv
// rtl/adc_iface_pkg.sv - shared types and constants for the ADC decimating capture block
package adc_iface_pkg;

  typedef enum logic {
    MODE_PICK = 1'b0,
    MODE_AVG  = 1'b1
  } mode_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_CNT_W  = 24;

  // LED bit positions: three result MSBs on top, stickies in the middle, result LSBs below
  localparam int LED_W      = 8;
  localparam int LED_HI_LSB = 5;
  localparam int LED_OVR    = 4;
  localparam int LED_OFA    = 3;
  localparam int LED_LO_LSB = 0;

endpackage

// File: rtl/decim_window_counter.sv
// rtl/decim_window_counter.sv - window length latch and sample counter for decimation
module decim_window_counter
  import adc_iface_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = 4
) (
  input  logic             clkouta,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic [CNT_W-1:0] decim_ratio,
  output logic             win_start,
  output logic             win_end,
  output mode_e            win_mode
);

  localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] AVG_N = ONE << AVG_LOG2;

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] n_lat;
  logic [CNT_W-1:0] n_new;
  logic [CNT_W-1:0] n_cur;
  mode_e            mode_lat;
  logic             at_zero;

  // At counter 0 the window parameters come straight from the inputs so a
  // one-sample window can open and close in the same cycle.
  always_comb begin
    at_zero   = (cnt == '0);
    win_mode  = at_zero ? mode_e'(mode) : mode_lat;
    if (win_mode == MODE_AVG) begin
      n_new = AVG_N;
    end else if (decim_ratio == '0) begin
      n_new = ONE;
    end else begin
      n_new = decim_ratio;
    end
    n_cur     = at_zero ? n_new : n_lat;
    win_start = enable && at_zero;
    win_end   = enable && (cnt == (n_cur - ONE));
  end

  // Count samples; disabling parks the counter at 0 and abandons the window.
  always_ff @(posedge clkouta or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      n_lat    <= ONE;
      mode_lat <= MODE_PICK;
    end else if (!enable) begin
      cnt <= '0;
    end else begin
      if (win_start) begin
        n_lat    <= n_new;
        mode_lat <= mode_e'(mode);
      end
      cnt <= win_end ? '0 : (cnt + ONE);
    end
  end

endmodule

// File: rtl/adc_decimating_capture.sv
// rtl/adc_decimating_capture.sv - ADC stream decimator (pick/boxcar) with handshake, overrun stats and LEDs
module adc_decimating_capture
  import adc_iface_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int CNT_W    = DEF_CNT_W,
  parameter int AVG_LOG2 = 4,
  parameter int OVR_W    = 8
) (
  input  logic              clkouta,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  input  logic [CNT_W-1:0]  decim_ratio,
  input  logic              clear_stats,
  input  logic [DATA_W-1:0] data_in,
  input  logic              ofa,
  output logic [DATA_W-1:0] data_out,
  output logic              data_out_ofa,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [OVR_W-1:0]  overrun_cnt,
  output logic [7:0]        LED
);

  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic              win_start;
  logic              win_end;
  mode_e             win_mode;
  logic [ACC_W-1:0]  acc;
  logic [ACC_W-1:0]  acc_sum;
  logic              win_ofa;
  logic              ofa_sum;
  logic [DATA_W-1:0] result;
  logic              accept;
  logic              load;
  logic              overrun;
  logic              ovr_sticky;
  logic              ofa_sticky;
  logic [2:0]        led_hi;
  logic [2:0]        led_lo;

  decim_window_counter #(
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2)
  ) u_win (
    .clkouta     (clkouta),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .decim_ratio (decim_ratio),
    .win_start   (win_start),
    .win_end     (win_end),
    .win_mode    (win_mode)
  );

  // Running sum / OR including the current sample; window start restarts from zero
  // so consecutive windows need no gap cycle.
  always_comb begin
    acc_sum = (win_start ? '0 : acc) + ACC_W'(data_in);
    ofa_sum = (win_start ? 1'b0 : win_ofa) | ofa;
    result  = (win_mode == MODE_AVG) ? DATA_W'(acc_sum >> AVG_LOG2) : data_in;
    accept  = data_out_valid && data_out_ready;
    load    = win_end && (!data_out_valid || data_out_ready);
    overrun = win_end && data_out_valid && !data_out_ready;
  end

  // Window accumulator and overrange OR; cleared while disabled and at window end.
  always_ff @(posedge clkouta or negedge rst_n) begin
    if (!rst_n) begin
      acc     <= '0;
      win_ofa <= 1'b0;
    end else if (!enable || win_end) begin
      acc     <= '0;
      win_ofa <= 1'b0;
    end else begin
      acc     <= acc_sum;
      win_ofa <= ofa_sum;
    end
  end

  // Output register: a held result is never overwritten; a result closing in the
  // acceptance cycle replaces the departing one without a bubble.
  always_ff @(posedge clkouta or negedge rst_n) begin
    if (!rst_n) begin
      data_out       <= '0;
      data_out_ofa   <= 1'b0;
      data_out_valid <= 1'b0;
      led_hi         <= '0;
      led_lo         <= '0;
    end else if (load) begin
      data_out       <= result;
      data_out_ofa   <= ofa_sum;
      data_out_valid <= 1'b1;
      led_hi         <= result[DATA_W-1 -: 3];
      led_lo         <= result[2:0];
    end else if (accept) begin
      data_out_valid <= 1'b0;
    end
  end

  // Overrun counter and sticky flags; clear_stats takes priority over new events.
  always_ff @(posedge clkouta or negedge rst_n) begin
    if (!rst_n) begin
      overrun_cnt <= '0;
      ovr_sticky  <= 1'b0;
      ofa_sticky  <= 1'b0;
    end else if (clear_stats) begin
      overrun_cnt <= '0;
      ovr_sticky  <= 1'b0;
      ofa_sticky  <= 1'b0;
    end else begin
      if (overrun) begin
        ovr_sticky <= 1'b1;
        if (overrun_cnt != '1) begin
          overrun_cnt <= overrun_cnt + OVR_W'(1);
        end
      end
      if (load && ofa_sum) begin
        ofa_sticky <= 1'b1;
      end
    end
  end

  // LED map: registered result bits plus live stickies.
  always_comb begin
    LED                    = '0;
    LED[LED_HI_LSB +: 3]   = led_hi;
    LED[LED_OVR]           = ovr_sticky;
    LED[LED_OFA]           = ofa_sticky;
    LED[LED_LO_LSB +: 3]   = led_lo;
  end

endmodule

// File: tb/tb_adc_decimating_capture.sv
// tb/tb_adc_decimating_capture.sv - self-checking bench for adc_decimating_capture
module tb_adc_decimating_capture;

  localparam int DATA_W   = 16;
  localparam int CNT_W    = 24;
  localparam int AVG_LOG2 = 2;
  localparam int OVR_W    = 8;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              ofa;
  } exp_t;

  logic              clkouta = 1'b0;
  logic              rst_n;
  logic              enable;
  logic              mode;
  logic [CNT_W-1:0]  decim_ratio;
  logic              clear_stats;
  logic [DATA_W-1:0] data_in;
  logic              ofa;
  logic [DATA_W-1:0] data_out;
  logic              data_out_ofa;
  logic              data_out_valid;
  logic              data_out_ready;
  logic [OVR_W-1:0]  overrun_cnt;
  logic [7:0]        LED;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  adc_decimating_capture #(
    .DATA_W   (DATA_W),
    .CNT_W    (CNT_W),
    .AVG_LOG2 (AVG_LOG2),
    .OVR_W    (OVR_W)
  ) dut (
    .clkouta        (clkouta),
    .rst_n          (rst_n),
    .enable         (enable),
    .mode           (mode),
    .decim_ratio    (decim_ratio),
    .clear_stats    (clear_stats),
    .data_in        (data_in),
    .ofa            (ofa),
    .data_out       (data_out),
    .data_out_ofa   (data_out_ofa),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .overrun_cnt    (overrun_cnt),
    .LED            (LED)
  );

  always #5 clkouta = ~clkouta;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [DATA_W-1:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ofa  = o;
    sb.push_back(e);
  endtask

  // At the falling edge, a valid&&ready word is the one the next rising edge accepts.
  task automatic tick();
    exp_t e;
    @(negedge clkouta);
    if (data_out_valid && data_out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL sb_unexpected observed=%0h expected=none", data_out);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_data", 32'(data_out), 32'(e.data));
        chk("sb_ofa", 32'(data_out_ofa), 32'(e.ofa));
      end
    end
    @(posedge clkouta);
    #1;
  endtask

  task automatic feed(input logic [DATA_W-1:0] d, input logic o);
    data_in = d;
    ofa     = o;
    tick();
  endtask

  initial begin
    rst_n          = 1'b0;
    enable         = 1'b0;
    mode           = 1'b0;
    decim_ratio    = '0;
    clear_stats    = 1'b0;
    data_in        = '0;
    ofa            = 1'b0;
    data_out_ready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_data", 32'(data_out), 32'h0);
    chk("rst_valid", 32'(data_out_valid), 32'h0);
    chk("rst_ofa", 32'(data_out_ofa), 32'h0);
    chk("rst_ovr", 32'(overrun_cnt), 32'h0);
    chk("rst_led", 32'(LED), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: PICK ratio 4, ramp input
    mode        = 1'b0;
    decim_ratio = 24'd4;
    enable      = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i % 4 == 3) push(DATA_W'(i), 1'b0);
      feed(DATA_W'(i), 1'b0);
      chk($sformatf("t1_valid_%0d", i), 32'(data_out_valid), (i % 4 == 3) ? 32'h1 : 32'h0);
    end
    enable = 1'b0;
    tick();

    // 2: AVG (window 4), then full-scale window
    mode   = 1'b1;
    enable = 1'b1;
    push(16'd25, 1'b0);
    feed(16'd10, 1'b0);
    feed(16'd20, 1'b0);
    feed(16'd30, 1'b0);
    feed(16'd41, 1'b0);
    chk("t2_led_avg", 32'(LED), 32'h01);
    push(16'hFFFF, 1'b0);
    for (int i = 0; i < 4; i++) feed(16'hFFFF, 1'b0);
    chk("t2_full_data", 32'(data_out), 32'hFFFF);
    chk("t2_led_full", 32'(LED), 32'hE7);
    enable = 1'b0;
    tick();

    // 3: PICK ratio 2 with backpressure across three windows
    mode           = 1'b0;
    decim_ratio    = 24'd2;
    data_out_ready = 1'b0;
    enable         = 1'b1;
    push(16'd101, 1'b0);
    feed(16'd100, 1'b0);
    feed(16'd101, 1'b0);
    chk("t3_first", 32'(data_out), 32'd101);
    feed(16'd102, 1'b0);
    feed(16'd103, 1'b0);
    feed(16'd104, 1'b0);
    feed(16'd105, 1'b0);
    chk("t3_held", 32'(data_out), 32'd101);
    chk("t3_held_valid", 32'(data_out_valid), 32'h1);
    chk("t3_ovr", 32'(overrun_cnt), 32'd2);
    chk("t3_led_ovr", 32'(LED[4]), 32'h1);
    enable         = 1'b0;
    data_out_ready = 1'b1;
    tick();
    chk("t3_drained", 32'(data_out_valid), 32'h0);
    clear_stats = 1'b1;
    tick();
    clear_stats = 1'b0;
    chk("t3_clr_ovr", 32'(overrun_cnt), 32'h0);
    chk("t3_clr_led", 32'(LED[4]), 32'h0);

    // Overrun saturation, then clear coinciding with an overrun
    decim_ratio    = 24'd1;
    data_out_ready = 1'b0;
    enable         = 1'b1;
    push(16'd7, 1'b0);
    for (int i = 0; i < 261; i++) feed(16'd7, 1'b0);
    chk("sat_ovr", 32'(overrun_cnt), 32'd255);
    clear_stats = 1'b1;
    feed(16'd9, 1'b0);
    clear_stats = 1'b0;
    chk("sat_clr_wins", 32'(overrun_cnt), 32'h0);
    chk("sat_clr_led", 32'(LED[4]), 32'h0);
    enable         = 1'b0;
    data_out_ready = 1'b1;
    tick();

    // 4: overrange on the middle sample of a ratio-5 window
    decim_ratio = 24'd5;
    enable      = 1'b1;
    push(16'd54, 1'b1);
    for (int i = 0; i < 5; i++) feed(DATA_W'(50 + i), (i == 2));
    chk("t4_ofa", 32'(data_out_ofa), 32'h1);
    chk("t4_led_ofa", 32'(LED[3]), 32'h1);
    push(16'd59, 1'b0);
    for (int i = 0; i < 5; i++) feed(DATA_W'(55 + i), 1'b0);
    chk("t4_ofa_next", 32'(data_out_ofa), 32'h0);
    enable = 1'b0;
    tick();

    // 5: ratio 0 and 1 give a result every cycle; ratio change mid-window
    decim_ratio = 24'd0;
    enable      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      push(DATA_W'(200 + i), 1'b0);
      feed(DATA_W'(200 + i), 1'b0);
      chk($sformatf("t5_r0_valid_%0d", i), 32'(data_out_valid), 32'h1);
    end
    decim_ratio = 24'd1;
    for (int i = 0; i < 3; i++) begin
      push(DATA_W'(210 + i), 1'b0);
      feed(DATA_W'(210 + i), 1'b0);
      chk($sformatf("t5_r1_valid_%0d", i), 32'(data_out_valid), 32'h1);
    end
    enable = 1'b0;
    tick();
    decim_ratio = 24'd3;
    enable      = 1'b1;
    feed(16'd300, 1'b0);
    decim_ratio = 24'd8;
    feed(16'd301, 1'b0);
    chk("t5_mid_nv", 32'(data_out_valid), 32'h0);
    push(16'd302, 1'b0);
    feed(16'd302, 1'b0);
    chk("t5_mid_close", 32'(data_out_valid), 32'h1);
    push(16'd310, 1'b0);
    for (int i = 0; i < 8; i++) feed(DATA_W'(303 + i), 1'b0);
    chk("t5_r8_close", 32'(data_out), 32'd310);
    enable = 1'b0;
    tick();

    // 6: asynchronous reset mid-window with a result pending
    decim_ratio    = 24'd4;
    data_out_ready = 1'b0;
    enable         = 1'b1;
    for (int i = 0; i < 6; i++) feed(DATA_W'(400 + i), 1'b1);
    chk("t6_pending", 32'(data_out_valid), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(data_out_valid), 32'h0);
    chk("t6_rst_data", 32'(data_out), 32'h0);
    chk("t6_rst_ofa", 32'(data_out_ofa), 32'h0);
    chk("t6_rst_ovr", 32'(overrun_cnt), 32'h0);
    chk("t6_rst_led", 32'(LED), 32'h0);
    tick();
    rst_n          = 1'b1;
    data_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) push(16'd503, 1'b0);
      feed(DATA_W'(500 + i), 1'b0);
      chk($sformatf("t6_fresh_valid_%0d", i), 32'(data_out_valid), (i == 3) ? 32'h1 : 32'h0);
    end
    enable = 1'b0;
    tick();
    tick();
    chk("sb_left", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
